// File: rtl/lc3_mem_responder_if.sv
// ---------------------------------------------------------------------------
// lc3_mem_responder_if
//   Memory request/response signals between the LC-3 CPU (master) and the
//   memory responder (slave).
//   MEM_EN : request, held high by the CPU until R is seen
//   WE     : 1 = write, 0 = read
//   ADDR   : word address (from MAR)
//   WDATA  : write data (from MDR)
//   RDATA  : registered read data (to MDR mux)
//   R      : one-cycle ready pulse
//   Busy   : responder FSM not idle
// ---------------------------------------------------------------------------
interface lc3_mem_responder_if;
    logic        MEM_EN;
    logic        WE;
    logic [15:0] ADDR;
    logic [15:0] WDATA;
    logic [15:0] RDATA;
    logic        R;
    logic        Busy;

    modport master (
        output MEM_EN, WE, ADDR, WDATA,
        input  RDATA, R, Busy
    );

    modport slave (
        input  MEM_EN, WE, ADDR, WDATA,
        output RDATA, R, Busy
    );
endinterface

// File: rtl/lc3_mem_responder.sv
// ---------------------------------------------------------------------------
// lc3_mem_responder
//   Memory-side responder for the LC-3 MAR/MDR interface: on-chip word RAM
//   plus one memory-mapped I/O word (Switches on read, HexOut on write).
//   A request is captured, held for WAIT_STATES cycles, performed in a single
//   ACCESS cycle, and acknowledged with a one-cycle R pulse. The FSM then
//   waits in DONE until MEM_EN drops (four-phase handshake).
//
//   Ports:
//     Clk      : system clock, rising edge
//     Reset_n  : asynchronous active-low reset
//     bus      : request/response interface (slave modport)
//     Switches : value returned on a read of IO_ADDR
//     HexOut   : I/O write register
//     Err      : sticky out-of-range flag
//
//   Optional feature, macro MEM_RANGE_CHECK_EN:
//     defined   - non-IO addresses >= DEPTH are dropped on write, read as
//                 zero, and set the sticky Err flag.
//     undefined - addresses alias modulo DEPTH, Err is tied low.
//
//   DEPTH must be a power of two in 2..32768; WAIT_STATES in 0..15.
// ---------------------------------------------------------------------------
module lc3_mem_responder #(
    parameter int          DEPTH       = 256,
    parameter int          WAIT_STATES = 2,
    parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
    input  logic                      Clk,
    input  logic                      Reset_n,
    lc3_mem_responder_if.slave        bus,
    input  logic [15:0]               Switches,
    output logic [15:0]               HexOut,
    output logic                      Err
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic        r_q, r_d;
    logic [15:0] hex_q, hex_d;

    logic [15:0] mem [DEPTH];

    logic          io_hit;
    logic          oor;
    logic [AW-1:0] ram_idx;
    logic          ram_we;

    assign io_hit  = (addr_q == IO_ADDR);
    assign ram_idx = addr_q[AW-1:0];

`ifdef MEM_RANGE_CHECK_EN
    logic err_q, err_d;
    assign oor = !io_hit && (addr_q >= 16'(DEPTH));
    assign Err = err_q;
`else
    assign oor = 1'b0;
    assign Err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state / datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        r_d     = 1'b0;
        hex_d   = hex_q;
`ifdef MEM_RANGE_CHECK_EN
        err_d   = err_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (bus.MEM_EN) begin
                    addr_d  = bus.ADDR;
                    we_d    = bus.WE;
                    wdata_d = bus.WDATA;
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
                end
            end
            S_WAIT: begin
                // Counter was loaded with WAIT_STATES, so leaving at 1
                // gives exactly WAIT_STATES cycles here.
                if (cnt_q != 4'd0)
                    cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1)
                    state_d = S_ACCESS;
            end
            S_ACCESS: begin
                r_d     = 1'b1;
                state_d = S_DONE;
                if (io_hit) begin
                    if (we_q) hex_d   = wdata_q;
                    else      rdata_d = Switches;
                end else if (oor) begin
                    if (!we_q) rdata_d = 16'h0000;
`ifdef MEM_RANGE_CHECK_EN
                    err_d = 1'b1;
`endif
                end else if (!we_q) begin
                    rdata_d = mem[ram_idx];
                end
            end
            S_DONE: begin
                // MEM_EN may already be low if the CPU violated the
                // handshake; we still completed the access, just go home.
                if (!bus.MEM_EN)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Control / output registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 16'h0000;
            we_q    <= 1'b0;
            wdata_q <= 16'h0000;
            rdata_q <= 16'h0000;
            r_q     <= 1'b0;
            hex_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            r_q     <= r_d;
            hex_q   <= hex_d;
        end
    end

`ifdef MEM_RANGE_CHECK_EN
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) err_q <= 1'b0;
        else          err_q <= err_d;
    end
`endif

    // ------------------------------------------------------------------
    // RAM array: not reset. The write is gated by Reset_n so a reset
    // coinciding with the ACCESS edge abandons the write.
    // ------------------------------------------------------------------
    assign ram_we = (state_q == S_ACCESS) && we_q && !io_hit && !oor && Reset_n;

    always_ff @(posedge Clk) begin
        if (ram_we)
            mem[ram_idx] <= wdata_q;
    end

    assign bus.RDATA = rdata_q;
    assign bus.R     = r_q;
    assign bus.Busy  = (state_q != S_IDLE);
    assign HexOut    = hex_q;

endmodule

// File: tb/tb_lc3_mem_responder.sv
module tb_lc3_mem_responder;
    localparam int          DEPTH = 256;
    localparam int          WS    = 2;
    localparam logic [15:0] IOA   = 16'hFFFF;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [15:0] Switches;
    logic [15:0] HexOut;
    logic        Err;

    lc3_mem_responder_if bus ();

    lc3_mem_responder #(.DEPTH(DEPTH), .WAIT_STATES(WS), .IO_ADDR(IOA)) dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .bus      (bus),
        .Switches (Switches),
        .HexOut   (HexOut),
        .Err      (Err)
    );

    always #5 Clk = ~Clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: word array with written-flags, plus output registers.
    logic [15:0] mm [DEPTH];
    bit          mv [DEPTH];
    logic [15:0] rd_m;
    bit          rd_known;
    logic [15:0] hex_m;
    logic        err_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        rd_m = 16'h0000; rd_known = 1; hex_m = 16'h0000; err_m = 1'b0;
    endtask

    task automatic model_access(input logic we, input logic [15:0] a, input logic [15:0] d);
        bit oor;
        int idx;
        idx = int'(a) % DEPTH;
`ifdef MEM_RANGE_CHECK_EN
        oor = (a != IOA) && (int'(a) >= DEPTH);
`else
        oor = 0;
`endif
        if (a == IOA) begin
            if (we) hex_m = d;
            else begin rd_m = Switches; rd_known = 1; end
        end else if (oor) begin
            err_m = 1'b1;
            if (!we) begin rd_m = 16'h0000; rd_known = 1; end
        end else if (we) begin
            mm[idx] = d; mv[idx] = 1;
        end else begin
            rd_m = mm[idx]; rd_known = mv[idx];
        end
    endtask

    task automatic check_outputs(input string tag);
        if (rd_known) check({tag, "_rdata"}, {16'h0, bus.RDATA}, {16'h0, rd_m});
        check({tag, "_hex"}, {16'h0, HexOut}, {16'h0, hex_m});
        check({tag, "_err"}, {31'h0, Err}, {31'h0, err_m});
    endtask

    // One full request: MEM_EN raised at a negedge, accepted at the next
    // posedge. R must appear at the (WS+2)th following negedge. Request
    // fields are scrambled after acceptance to prove they were captured.
    task automatic req(input logic we, input logic [15:0] a, input logic [15:0] d, input int hold);
        int cyc;
        bit got;
        @(negedge Clk);
        bus.MEM_EN = 1'b1; bus.WE = we; bus.ADDR = a; bus.WDATA = d;
        cyc = 0; got = 0;
        while (!got && cyc < 40) begin
            @(negedge Clk);
            cyc++;
            if (cyc == 1) begin
                bus.WE = ~we; bus.ADDR = 16'($urandom); bus.WDATA = 16'($urandom);
            end
            if (bus.R === 1'b1) got = 1;
            else check("busy_wait", {31'h0, bus.Busy}, 32'h1);
        end
        check("r_latency", cyc, WS + 2);
        model_access(we, a, d);
        check_outputs("resp");
        for (int i = 0; i < hold; i++) begin
            @(negedge Clk);
            check("hold_r", {31'h0, bus.R}, 32'h0);
            check("hold_busy", {31'h0, bus.Busy}, 32'h1);
        end
        bus.MEM_EN = 1'b0;
        @(negedge Clk);
        check("idle_busy", {31'h0, bus.Busy}, 32'h0);
        check("idle_r", {31'h0, bus.R}, 32'h0);
    endtask

    initial begin
        logic [15:0] a;
        Reset_n = 1'b0;
        bus.MEM_EN = 1'b0; bus.WE = 1'b0; bus.ADDR = 16'h0; bus.WDATA = 16'h0;
        Switches = 16'h0;
        for (int i = 0; i < DEPTH; i++) begin mm[i] = 16'h0; mv[i] = 0; end
        model_reset();
        #12;
        check("rst_r", {31'h0, bus.R}, 32'h0);
        check("rst_busy", {31'h0, bus.Busy}, 32'h0);
        check("rst_rdata", {16'h0, bus.RDATA}, 32'h0);
        check("rst_hex", {16'h0, HexOut}, 32'h0);
        check("rst_err", {31'h0, Err}, 32'h0);
        @(negedge Clk);
        Reset_n = 1'b1;

        // Write then read back
        req(1'b1, 16'h0010, 16'h1234, 0);
        req(1'b0, 16'h0010, 16'h0000, 0);

        // I/O write, RAM at 0x00FF unaffected
        req(1'b1, 16'h00FF, 16'hCAFE, 0);
        req(1'b1, 16'hFFFF, 16'hBEEF, 0);
        req(1'b0, 16'h00FF, 16'h0000, 0);

        // I/O read; later Switches change must not disturb RDATA
        Switches = 16'h00A5;
        req(1'b0, 16'hFFFF, 16'h0000, 0);
        Switches = 16'h0000;
        repeat (3) @(negedge Clk);
        check("io_rdata_hold", {16'h0, bus.RDATA}, 32'h00A5);

        // Long handshake hold, then immediate re-request
        req(1'b0, 16'h0010, 16'h0000, 10);
        req(1'b0, 16'h0010, 16'h0000, 0);

        // Reset during WAIT abandons the write
        req(1'b1, 16'h0020, 16'h1111, 0);
        @(negedge Clk);
        bus.MEM_EN = 1'b1; bus.WE = 1'b1; bus.ADDR = 16'h0020; bus.WDATA = 16'h5555;
        @(negedge Clk);
        check("abort_busy_pre", {31'h0, bus.Busy}, 32'h1);
        Reset_n = 1'b0;
        #1;
        check("abort_r", {31'h0, bus.R}, 32'h0);
        check("abort_busy", {31'h0, bus.Busy}, 32'h0);
        model_reset();
        bus.MEM_EN = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
        check_outputs("post_rst");
        req(1'b0, 16'h0020, 16'h0000, 0);

        // Out-of-range write: aliases or is dropped depending on build
        req(1'b1, 16'h0110, 16'h7777, 0);
        req(1'b0, 16'h0010, 16'h0000, 0);
        req(1'b0, 16'h0110, 16'h0000, 1);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 7))
                0:       a = IOA;
                1:       a = 16'h0100 | 16'($urandom_range(0, 31));
                default: a = 16'($urandom_range(0, 31));
            endcase
            Switches = 16'($urandom);
            req(1'($urandom_range(0, 1)), a, 16'($urandom), $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
